// File: rtl/clk_div_if.sv
// Control/status bundle between a clock-divider client and clk_div_ctrl.
// The client (master) drives the run controls; the divider (slave) drives status.
interface clk_div_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned RUN_W = 16
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] half_period;
    logic [RUN_W-1:0] num_cycles;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic             done;
    logic [RUN_W-1:0] cycles_done;

    modport master (
        output start, stop, half_period, num_cycles,
        input  clk_out, tick, busy, done, cycles_done
    );

    modport slave (
        input  start, stop, half_period, num_cycles,
        output clk_out, tick, busy, done, cycles_done
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable controller: divided clock plus rising-edge tick,
// for a fixed number of output periods or free-running.
module clk_div_ctrl #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned RUN_W = 16
) (
    input logic      clk,
    input logic      rst,
    clk_div_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [RUN_W-1:0] nl_q, nl_d;
    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic [RUN_W-1:0] cycles_q, cycles_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] hp_eff;

    // A programmed half period of zero behaves as one.
    assign hp_eff = (bus.half_period == '0) ? CNT_W'(1) : bus.half_period;

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        nl_d       = nl_q;
        half_cnt_d = half_cnt_q;
        cycles_d   = cycles_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.stop) begin
                    state_d   = StIdle;
                    clk_out_d = 1'b0;
                end else if (bus.start) begin
                    state_d    = StRun;
                    hp_d       = hp_eff;
                    nl_d       = bus.num_cycles;
                    half_cnt_d = '0;
                    cycles_d   = '0;
                    clk_out_d  = 1'b0;
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d   = StIdle;
                    clk_out_d = 1'b0;
                end else if (half_cnt_q == hp_q - CNT_W'(1)) begin
                    half_cnt_d = '0;
                    clk_out_d  = ~clk_out_q;
                    if (!clk_out_q) begin
                        tick_d   = 1'b1;
                        cycles_d = cycles_q + RUN_W'(1);
                    end else if (nl_q != '0 && cycles_q == nl_q) begin
                        // Falling edge after the last requested period.
                        state_d = StDone;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = StIdle;
                clk_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            hp_q       <= CNT_W'(1);
            nl_q       <= '0;
            half_cnt_q <= '0;
            cycles_q   <= '0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            nl_q       <= nl_d;
            half_cnt_q <= half_cnt_d;
            cycles_q   <= cycles_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.clk_out     = clk_out_q;
    assign bus.tick        = tick_q;
    assign bus.busy        = (state_q == StRun);
    assign bus.done        = (state_q == StDone);
    assign bus.cycles_done = cycles_q;

endmodule
